stop_watch_ctrl: RTL and testbench
==================================

Name: stop_watch_ctrl

Overview:
Run/stop/lap/clear sequencer for the stopwatch counter chain (1 kHz prescaler -> pls_cnt_10 -> pls_cnt_100 -> hex2seg).
- Debounces three raw push-buttons.
- Converts button presses into single press events.
- Runs a 4-state FSM that drives the counter enable, the counter clear, lap capture and the display-hold select.
- Sits between the board buttons and the counter datapath, in the same clock domain.

Parameters:
DEB_TICKS, 20, number of consecutive tick_1k strobes a synchronized button level must hold before it is accepted (20 = 20 ms)
DEB_W, 5, width of each debounce counter; must satisfy 2^DEB_W > DEB_TICKS

Ports:
clk  input  1  system clock (100 MHz board clock)
rst  input  1  reset, active-low; synchronous to clk
tick_1k  input  1  one-clk strobe at 1 kHz from the prescaler; debounce timebase
btn_start  input  1  raw start/stop toggle button, active-high, asynchronous
btn_lap  input  1  raw lap button, active-high, asynchronous
btn_clr  input  1  raw clear button, active-high, asynchronous
cnt_en  output  1  level; counter chain advances while 1
cnt_clr  output  1  one-clk pulse; synchronously clears all stopwatch counters
lap_stb  output  1  one-clk pulse; lap register captures the live count
disp_hold  output  1  level; 1 = display shows the lap register, 0 = live count
state  output  2  current FSM state, for debug LEDs

Behaviour:
- Reset (rst==0 sampled at posedge clk):
  - state=IDLE.
  - cnt_en=0, cnt_clr=0, lap_stb=0, disp_hold=0.
  - Synchronizer flops, debounced levels and debounce counters all = 0.
- Input conditioning, per button:
  - 2-FF synchronizer.
  - Debounce counter increments on tick_1k while the synced level differs from the debounced level.
  - The counter resets to 0 whenever the synced level equals the debounced level.
  - When the counter reaches DEB_TICKS on a tick, the debounced level flips and the counter returns to 0.
  - A 0->1 transition of the debounced level produces a one-clk press event.
  - A 1->0 transition produces no event.
- Latency:
  - Debounced rising edge -> press event: same clk.
  - Press event -> state and output change: registered, visible 1 clk later.
- Priority: if several press events occur in the same clk, only the highest is processed (clr > start > lap). The others are dropped, not queued.
- State encoding: IDLE=2'b00, RUN=2'b01, LAP=2'b10, STOP=2'b11.
- FSM transitions:
  - IDLE:
    - start -> RUN.
    - clr -> cnt_clr pulse, stay IDLE.
    - lap ignored.
  - RUN:
    - start -> STOP.
    - lap -> LAP with lap_stb pulse.
    - clr ignored.
  - LAP:
    - lap -> lap_stb pulse, stay LAP (new split).
    - start -> STOP.
    - clr ignored.
  - STOP:
    - start -> RUN; the count resumes without clearing.
    - clr -> cnt_clr pulse, then IDLE.
    - lap ignored.
- Output decode (registered):
  - cnt_en=1 in RUN and LAP.
  - disp_hold=1 only in LAP.
  - cnt_clr and lap_stb are never high for more than 1 clk.
- Timing independence: tick_1k only gates debounce. FSM transitions occur on any clk that has an event.
- Reset mid-operation: all of the above reset values apply on the next edge. No cnt_clr pulse is generated by reset; the counters take rst directly.
- A button held indefinitely yields exactly one event until it is released and pressed again.

Optional Feature:
STOPWATCH_LAP_EN
- Defined: LAP state and lap_stb exist as described.
- Undefined:
  - The lap debouncer is not instantiated.
  - lap_stb and disp_hold are tied 0.
  - The LAP encoding is unreachable. A state register holding 2'b10 recovers to IDLE on the next clk.
  - btn_lap is left unused.

Decomposition:
- Package stop_watch_pkg holds:
  - The state encoding constants IDLE/RUN/LAP/STOP.
  - Default DEB_TICKS.
  - The button-index constants BTN_START=0, BTN_LAP=1, BTN_CLR=2.
- One sub-module, btn_debounce (synchronizer + counter + rising-edge event), instantiated once per button. Parameters: DEB_TICKS, DEB_W. Ports: clk, rst, tick_1k, btn_raw, btn_lvl, btn_evt.
- The FSM and output decode stay in stop_watch_ctrl.

Test Plan:
1. Debounce accept: DEB_TICKS=4, tick every 10 clk; hold btn_start=1 for 60 clk. Expect one press event, state 00->01 and cnt_en=1 within 3 synchronizer clk after the 4th tick.
2. Bounce reject: toggle btn_start every 15 clk for 200 clk. Expect no event, state stays IDLE, cnt_en=0.
3. Full sequence: start, lap, lap, start, clr (each a clean 60 clk press). Expect states 01, 10, 10, 11, 00. Expect lap_stb pulsed exactly twice, disp_hold=1 only in LAP, and one cnt_clr pulse on entering IDLE.
4. Simultaneous events: in STOP, force btn_clr and btn_start to debounce in the same clk. Expect cnt_clr pulse and IDLE; the start event is dropped and the state does not go to RUN.
5. Ignored buttons: in RUN, press clr, then confirm no cnt_clr and state stays 01. In IDLE, press lap, then confirm no lap_stb.
6. Reset mid-run: in LAP, drive rst=0 for 1 clk. On the next edge expect state=00, all outputs 0 and no cnt_clr pulse. Repeat with STOPWATCH_LAP_EN undefined: a lap press never changes state from 01.

Source files
------------

// File: rtl/stop_watch_pkg.sv
// Shared constants for the stopwatch run/stop/lap/clear sequencer.
// The lap feature is compiled in only when STOPWATCH_LAP_EN is defined.
package stop_watch_pkg;

   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] RUN  = 2'b01;
   localparam logic [1:0] LAP  = 2'b10;
   localparam logic [1:0] STOP = 2'b11;

   localparam int DEB_TICKS_DEF = 20;

   localparam int BTN_START = 0;
   localparam int BTN_LAP   = 1;
   localparam int BTN_CLR   = 2;

endpackage

// File: rtl/stop_watch_ctrl_btn_debounce.sv
// One push-button conditioner: 2-FF synchronizer, tick-based debounce counter
// and a one-clk press event on each accepted 0->1 transition.
module btn_debounce #(
   parameter int DEB_TICKS = 20,
   parameter int DEB_W     = 5
) (
   input  logic clk,
   input  logic rst,
   input  logic tick_1k,
   input  logic btn_raw,
   output logic btn_lvl,
   output logic btn_evt
);

   localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_TICKS - 1);

   logic             sync1_q, sync2_q;
   logic             lvl_q, lvl_d;
   logic             evt_q, evt_d;
   logic [DEB_W-1:0] cnt_q, cnt_d;

   // The counter only advances while the synced input disagrees with the accepted level.
   always_comb begin
      cnt_d = cnt_q;
      lvl_d = lvl_q;
      evt_d = 1'b0;
      if (sync2_q == lvl_q) begin
         cnt_d = '0;
      end else if (tick_1k) begin
         if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            lvl_d = sync2_q;
            evt_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         lvl_q   <= 1'b0;
         evt_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
         lvl_q   <= lvl_d;
         evt_q   <= evt_d;
         cnt_q   <= cnt_d;
      end
   end

   assign btn_lvl = lvl_q;
   assign btn_evt = evt_q;

endmodule

// File: rtl/stop_watch_ctrl.sv
// Stopwatch sequencer: debounced buttons drive a 4-state FSM with registered outputs.
// Define STOPWATCH_LAP_EN to build the lap button, LAP state and lap_stb.
module stop_watch_ctrl
   import stop_watch_pkg::*;
#(
   parameter int DEB_TICKS = DEB_TICKS_DEF,
   parameter int DEB_W     = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_1k,
   input  logic       btn_start,
   input  logic       btn_lap,
   input  logic       btn_clr,
   output logic       cnt_en,
   output logic       cnt_clr,
   output logic       lap_stb,
   output logic       disp_hold,
   output logic [1:0] state
);

   logic [2:0] evt;
   logic [2:0] lvl_unused;
   logic [1:0] state_q, state_d;
   logic       cnt_en_q, cnt_clr_q, cnt_clr_d, lap_stb_q, lap_stb_d, disp_hold_q;
   logic       do_clr, do_start, do_lap;

   btn_debounce #(.DEB_TICKS(DEB_TICKS), .DEB_W(DEB_W)) u_deb_start (
      .clk(clk), .rst(rst), .tick_1k(tick_1k), .btn_raw(btn_start),
      .btn_lvl(lvl_unused[BTN_START]), .btn_evt(evt[BTN_START]));

   btn_debounce #(.DEB_TICKS(DEB_TICKS), .DEB_W(DEB_W)) u_deb_clr (
      .clk(clk), .rst(rst), .tick_1k(tick_1k), .btn_raw(btn_clr),
      .btn_lvl(lvl_unused[BTN_CLR]), .btn_evt(evt[BTN_CLR]));

`ifdef STOPWATCH_LAP_EN
   btn_debounce #(.DEB_TICKS(DEB_TICKS), .DEB_W(DEB_W)) u_deb_lap (
      .clk(clk), .rst(rst), .tick_1k(tick_1k), .btn_raw(btn_lap),
      .btn_lvl(lvl_unused[BTN_LAP]), .btn_evt(evt[BTN_LAP]));
`else
   logic unused_btn_lap;
   assign unused_btn_lap       = btn_lap;
   assign evt[BTN_LAP]        = 1'b0;
   assign lvl_unused[BTN_LAP] = 1'b0;
`endif

   // Only the highest-priority event in a clk is seen; lower ones are dropped.
   assign do_clr   = evt[BTN_CLR];
   assign do_start = evt[BTN_START] & ~evt[BTN_CLR];
   assign do_lap   = evt[BTN_LAP] & ~evt[BTN_START] & ~evt[BTN_CLR];

   always_comb begin
      state_d   = state_q;
      cnt_clr_d = 1'b0;
      lap_stb_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (do_clr)        cnt_clr_d = 1'b1;
            else if (do_start) state_d   = RUN;
         end
         RUN: begin
            if (do_start) state_d = STOP;
`ifdef STOPWATCH_LAP_EN
            else if (do_lap) begin
               state_d   = LAP;
               lap_stb_d = 1'b1;
            end
`endif
         end
         LAP: begin
`ifdef STOPWATCH_LAP_EN
            if (do_start)    state_d   = STOP;
            else if (do_lap) lap_stb_d = 1'b1;
`else
            state_d = IDLE;
`endif
         end
         STOP: begin
            if (do_clr) begin
               cnt_clr_d = 1'b1;
               state_d   = IDLE;
            end else if (do_start) begin
               state_d = RUN;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_en_q    <= 1'b0;
         cnt_clr_q   <= 1'b0;
         lap_stb_q   <= 1'b0;
         disp_hold_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_en_q    <= (state_d == RUN) || (state_d == LAP);
         cnt_clr_q   <= cnt_clr_d;
         lap_stb_q   <= lap_stb_d;
         disp_hold_q <= (state_d == LAP);
      end
   end

   assign state     = state_q;
   assign cnt_en    = cnt_en_q;
   assign cnt_clr   = cnt_clr_q;
   assign lap_stb   = lap_stb_q;
   assign disp_hold = disp_hold_q;

endmodule

// File: tb/tb_stop_watch_ctrl.sv
// Directed bench for stop_watch_ctrl with DEB_TICKS=4 and a tick every 10 clk.
// Lap-dependent expectations follow STOPWATCH_LAP_EN.
module tb_stop_watch_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       tick_1k = 1'b0;
   logic       btn_start = 1'b0;
   logic       btn_lap = 1'b0;
   logic       btn_clr = 1'b0;
   logic       cnt_en, cnt_clr, lap_stb, disp_hold;
   logic [1:0] state;

   int tests = 0;
   int fails = 0;
   int clr_pulses = 0;
   int lap_pulses = 0;
   bit clr_wide = 1'b0;
   bit lap_wide = 1'b0;
   logic prev_clr = 1'b0;
   logic prev_lap = 1'b0;

   stop_watch_ctrl #(.DEB_TICKS(4), .DEB_W(3)) dut (
      .clk(clk), .rst(rst), .tick_1k(tick_1k),
      .btn_start(btn_start), .btn_lap(btn_lap), .btn_clr(btn_clr),
      .cnt_en(cnt_en), .cnt_clr(cnt_clr), .lap_stb(lap_stb),
      .disp_hold(disp_hold), .state(state));

   always #5 clk = ~clk;

   initial begin
      int c = 0;
      forever begin
         @(negedge clk);
         c = (c == 9) ? 0 : c + 1;
         tick_1k = (c == 0);
      end
   end

   always @(negedge clk) begin
      if (cnt_clr === 1'b1) begin
         clr_pulses++;
         if (prev_clr === 1'b1) clr_wide = 1'b1;
      end
      if (lap_stb === 1'b1) begin
         lap_pulses++;
         if (prev_lap === 1'b1) lap_wide = 1'b1;
      end
      prev_clr = cnt_clr;
      prev_lap = lap_stb;
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // which: 0 start, 1 lap, 2 clr, 3 clr+start together
   task automatic press(input int which, input int hold);
      if (which == 0) btn_start = 1'b1;
      if (which == 1) btn_lap = 1'b1;
      if (which == 2) btn_clr = 1'b1;
      if (which == 3) begin btn_clr = 1'b1; btn_start = 1'b1; end
      wait_clk(hold);
      btn_start = 1'b0; btn_lap = 1'b0; btn_clr = 1'b0;
      wait_clk(70);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      wait_clk(1);
      rst = 1'b1;
      wait_clk(2);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      wait_clk(3);
      tests++; if (state !== 2'b00) begin fails++; $display("FAIL reset_state got %b want 00", state); end
      tests++; if ({cnt_en, cnt_clr, lap_stb, disp_hold} !== 4'b0000) begin
         fails++; $display("FAIL reset_outputs got %b want 0000", {cnt_en, cnt_clr, lap_stb, disp_hold}); end
      rst = 1'b1;
      wait_clk(2);
      clr_pulses = 0; lap_pulses = 0;
   endtask

   task automatic test_bounce_reject();
      for (int i = 0; i < 200; i++) begin
         if (i % 15 == 0) btn_start = ~btn_start;
         wait_clk(1);
      end
      btn_start = 1'b0;
      wait_clk(70);
      tests++; if (state !== 2'b00) begin fails++; $display("FAIL bounce_state got %b want 00", state); end
      tests++; if (cnt_en !== 1'b0) begin fails++; $display("FAIL bounce_cnt_en got %b want 0", cnt_en); end
   endtask

   task automatic test_debounce_accept();
      int lat = -1;
      btn_start = 1'b1;
      for (int i = 1; i <= 60; i++) begin
         wait_clk(1);
         if (lat < 0 && state === 2'b01) lat = i;
      end
      btn_start = 1'b0;
      wait_clk(70);
      tests++; if (lat < 30 || lat > 48) begin fails++; $display("FAIL accept_latency got %0d want 30..48", lat); end
      tests++; if (state !== 2'b01) begin fails++; $display("FAIL accept_state got %b want 01", state); end
      tests++; if (cnt_en !== 1'b1) begin fails++; $display("FAIL accept_cnt_en got %b want 1", cnt_en); end
   endtask

   task automatic test_held_button();
      do_reset();
      press(0, 300);
      tests++; if (state !== 2'b01) begin fails++; $display("FAIL held_one_event got %b want 01", state); end
   endtask

   task automatic test_full_sequence();
      logic [1:0] exp_lap;
      do_reset();
      clr_pulses = 0; lap_pulses = 0;
`ifdef STOPWATCH_LAP_EN
      exp_lap = 2'b10;
`else
      exp_lap = 2'b01;
`endif
      press(0, 60);
      tests++; if (state !== 2'b01) begin fails++; $display("FAIL seq_start got %b want 01", state); end
      press(1, 60);
      tests++; if (state !== exp_lap) begin fails++; $display("FAIL seq_lap1 got %b want %b", state, exp_lap); end
      tests++; if (disp_hold !== exp_lap[1]) begin fails++; $display("FAIL seq_hold1 got %b want %b", disp_hold, exp_lap[1]); end
      press(1, 60);
      tests++; if (state !== exp_lap) begin fails++; $display("FAIL seq_lap2 got %b want %b", state, exp_lap); end
      tests++; if (cnt_en !== 1'b1) begin fails++; $display("FAIL seq_lap_cnt_en got %b want 1", cnt_en); end
      press(0, 60);
      tests++; if (state !== 2'b11) begin fails++; $display("FAIL seq_stop got %b want 11", state); end
      tests++; if ({cnt_en, disp_hold} !== 2'b00) begin fails++; $display("FAIL seq_stop_out got %b want 00", {cnt_en, disp_hold}); end
      tests++; if (clr_pulses !== 0) begin fails++; $display("FAIL seq_no_clr_yet got %0d want 0", clr_pulses); end
      press(2, 60);
      tests++; if (state !== 2'b00) begin fails++; $display("FAIL seq_clr got %b want 00", state); end
      tests++; if (clr_pulses !== 1) begin fails++; $display("FAIL seq_clr_pulses got %0d want 1", clr_pulses); end
`ifdef STOPWATCH_LAP_EN
      tests++; if (lap_pulses !== 2) begin fails++; $display("FAIL seq_lap_pulses got %0d want 2", lap_pulses); end
`else
      tests++; if (lap_pulses !== 0) begin fails++; $display("FAIL seq_lap_pulses got %0d want 0", lap_pulses); end
`endif
   endtask

   task automatic test_simultaneous();
      press(0, 60);
      press(0, 60);
      tests++; if (state !== 2'b11) begin fails++; $display("FAIL simul_setup got %b want 11", state); end
      clr_pulses = 0;
      press(3, 60);
      tests++; if (state !== 2'b00) begin fails++; $display("FAIL simul_state got %b want 00", state); end
      tests++; if (clr_pulses !== 1) begin fails++; $display("FAIL simul_clr got %0d want 1", clr_pulses); end
      tests++; if (cnt_en !== 1'b0) begin fails++; $display("FAIL simul_cnt_en got %b want 0", cnt_en); end
   endtask

   task automatic test_ignored();
      press(0, 60);
      clr_pulses = 0;
      press(2, 60);
      tests++; if (state !== 2'b01) begin fails++; $display("FAIL ign_run_clr_state got %b want 01", state); end
      tests++; if (clr_pulses !== 0) begin fails++; $display("FAIL ign_run_clr_pulse got %0d want 0", clr_pulses); end
      press(0, 60);
      press(2, 60);
      lap_pulses = 0;
      press(1, 60);
      tests++; if (state !== 2'b00) begin fails++; $display("FAIL ign_idle_lap_state got %b want 00", state); end
      tests++; if (lap_pulses !== 0) begin fails++; $display("FAIL ign_idle_lap_pulse got %0d want 0", lap_pulses); end
   endtask

   task automatic test_reset_mid();
      press(0, 60);
      lap_pulses = 0;
      press(1, 60);
`ifdef STOPWATCH_LAP_EN
      tests++; if (state !== 2'b10) begin fails++; $display("FAIL mid_setup got %b want 10", state); end
`else
      tests++; if (state !== 2'b01) begin fails++; $display("FAIL mid_lap_disabled got %b want 01", state); end
      tests++; if (lap_pulses !== 0) begin fails++; $display("FAIL mid_lap_disabled_stb got %0d want 0", lap_pulses); end
`endif
      clr_pulses = 0;
      rst = 1'b0;
      wait_clk(1);
      tests++; if (state !== 2'b00) begin fails++; $display("FAIL mid_rst_state got %b want 00", state); end
      tests++; if ({cnt_en, cnt_clr, lap_stb, disp_hold} !== 4'b0000) begin
         fails++; $display("FAIL mid_rst_outputs got %b want 0000", {cnt_en, cnt_clr, lap_stb, disp_hold}); end
      rst = 1'b1;
      wait_clk(10);
      tests++; if (clr_pulses !== 0) begin fails++; $display("FAIL mid_rst_no_clr got %0d want 0", clr_pulses); end
      tests++; if (state !== 2'b00) begin fails++; $display("FAIL mid_rst_stays got %b want 00", state); end
   endtask

   initial begin
      test_reset();
      test_bounce_reject();
      test_debounce_accept();
      test_held_button();
      test_full_sequence();
      test_simultaneous();
      test_ignored();
      test_reset_mid();
      tests++; if (clr_wide !== 1'b0) begin fails++; $display("FAIL clr_width got wide want single"); end
      tests++; if (lap_wide !== 1'b0) begin fails++; $display("FAIL lap_width got wide want single"); end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
